op_sequencer: RTL and testbench

OP_SEQUENCER -- requirements
Module: op_sequencer

---
 rtl/seq_pkg.sv | 11 +
 rtl/button_debouncer.sv | 37 +++
 rtl/op_sequencer.sv | 75 +++++++
 tb/tb_op_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and default timing constants shared by op_sequencer and its debouncer
package seq_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HAVE_A = 2'd1,
      HAVE_B = 2'd2,
      SHOW   = 2'd3
   } state_t;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_TIMEOUT_CYCLES  = 1024;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer plus debounce filter; emits the filtered level and a one-cycle press pulse on its rising edge
module button_debouncer import seq_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_button,
   output logic o_level,
   output logic o_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_press;
   logic          w_diff;
   logic          w_done;
   assign w_diff  = r_sync[1] ^ r_level;
   assign w_done  = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign o_level = r_level;
   assign o_press = r_press;
   // bring the raw button into the clock domain
   always_ff @(posedge clk or posedge rst)
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[0], i_button};
   // count consecutive samples that disagree with the filtered level; any agreeing sample restarts the count
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_cnt   <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
         r_level <= w_done ? r_sync[1] : r_level;
         r_press <= w_done && r_sync[1];
      end
endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: button-driven A/B/result sequencer FSM; define SEQ_TIMEOUT_EN to abandon HAVE_A after TIMEOUT_CYCLES idle cycles
module op_sequencer import seq_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button,
   output logic       save_A,
   output logic       save_B,
   output logic       show_result,
   output logic       busy,
   output logic [1:0] state
);
   state_t r_state;
   state_t w_next;
   logic   w_level;
   logic   w_press;
   logic   w_evt;
   logic   w_timeout;
   logic   r_save_a;
   logic   r_save_b;
   logic   r_show;
   logic   r_busy;
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_button (button),
      .o_level  (w_level),
      .o_press  (w_press)
   );
   assign w_evt = w_press && w_level;
`ifdef SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] r_to;
   assign w_timeout = (r_state == HAVE_A) && (r_to == TW'(TIMEOUT_CYCLES - 1));
   // idle-cycle counter for HAVE_A; any other state or a press clears it, so entry always starts at zero
   always_ff @(posedge clk or posedge rst)
      if (rst) r_to <= '0;
      else     r_to <= (r_state == HAVE_A && !w_evt && !w_timeout) ? r_to + 1'b1 : '0;
`else
   assign w_timeout = 1'b0;
`endif
   // next-state logic; a press in HAVE_A outranks the timeout, presses in HAVE_B are dropped
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_evt ? HAVE_A : IDLE;
         HAVE_A:  w_next = w_evt ? HAVE_B : (w_timeout ? IDLE : HAVE_A);
         HAVE_B:  w_next = SHOW;
         SHOW:    w_next = w_evt ? HAVE_A : SHOW;
         default: w_next = IDLE;
      endcase
   end
   // state and pulses are registered together so each pulse coincides with its new state
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state  <= IDLE;
         r_save_a <= 1'b0;
         r_save_b <= 1'b0;
         r_show   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_save_a <= w_evt && (r_state == IDLE || r_state == SHOW);
         r_save_b <= w_evt && (r_state == HAVE_A);
         r_show   <= (r_state == HAVE_B);
         r_busy   <= (w_next != IDLE);
      end
   assign save_A      = r_save_a;
   assign save_B      = r_save_b;
   assign show_result = r_show;
   assign busy        = r_busy;
   assign state       = r_state;
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed table-driven bench for op_sequencer with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=32
module tb_op_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       button = 1'b0;
   logic       save_A, save_B, show_result, busy;
   logic [1:0] state;
   int checks = 0;
   int errors = 0;
   int n_a, n_b, n_s, n_multi;
   typedef struct {
      logic [31:0] pat;
      int len;
      int ea;
      int eb;
      int es;
      int est;
   } vec_t;
   vec_t vecs [9];

   op_sequencer #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .button      (button),
      .save_A      (save_A),
      .save_B      (save_B),
      .show_result (show_result),
      .busy        (busy),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic clr();
      n_a = 0; n_b = 0; n_s = 0; n_multi = 0;
   endtask

   task automatic step(input logic b);
      @(posedge clk);
      #1 button = b;
      @(negedge clk);
      n_a += int'(save_A);
      n_b += int'(save_B);
      n_s += int'(show_result);
      if (int'(save_A) + int'(save_B) + int'(show_result) > 1) n_multi++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      button = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit found;
      int bad;
      vecs[0] = '{32'b011,          3,  0, 0, 0, 0};
      vecs[1] = '{32'b0111,         4,  0, 0, 0, 0};
      vecs[2] = '{32'hFD5,          12, 1, 0, 0, 1};
      vecs[3] = '{32'b0,            1,  0, 0, 0, 1};
      vecs[4] = '{32'b01111,        5,  0, 1, 1, 3};
      vecs[5] = '{32'b1,            1,  1, 0, 0, 1};
      vecs[6] = '{32'b0,            1,  0, 0, 0, 1};
      vecs[7] = '{32'b1,            1,  0, 1, 1, 3};
      vecs[8] = '{32'b0,            1,  0, 0, 0, 3};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", int'(state), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pulses", int'(save_A) + int'(save_B) + int'(show_result), 0);
      rst = 1'b0;
      // clean press: save_A must appear on the 7th edge after the raw edge
      clr();
      for (int k = 1; k <= 7; k++) step(1'b1);
      chk("lat_early", n_a, 0);
      step(1'b1);
      chk("lat_edge", int'(save_A), 1);
      chk("lat_state", int'(state), 1);
      chk("lat_busy", int'(busy), 1);
      step(1'b1);
      chk("lat_width", int'(save_A), 0);
      repeat (11) step(1'b1);
      chk("lat_total", n_a, 1);
      do_reset();
      #1 chk("rst2_state", int'(state), 0);
      // table of raw patterns, each followed by 10 cycles at its final level
      for (int i = 0; i < 9; i++) begin
         clr();
         for (int c = 0; c < vecs[i].len; c++) step(vecs[i].pat[c]);
         repeat (10) step(vecs[i].pat[vecs[i].len-1]);
         chk($sformatf("v%0d_save_A", i), n_a, vecs[i].ea);
         chk($sformatf("v%0d_save_B", i), n_b, vecs[i].eb);
         chk($sformatf("v%0d_show", i), n_s, vecs[i].es);
         chk($sformatf("v%0d_state", i), int'(state), vecs[i].est);
         chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].est != 0));
         chk($sformatf("v%0d_onehot", i), n_multi, 0);
      end
      // SHOW + press -> HAVE_A, then idle in HAVE_A
      clr();
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(1'b1);
         found = save_A;
      end
      chk("to_press_found", int'(found), 1);
      chk("to_press_state", int'(state), 1);
`ifdef SEQ_TIMEOUT_EN
      for (int k = 1; k < 32; k++) step(1'b0);
      chk("to_before", int'(state), 1);
      step(1'b0);
      chk("to_state", int'(state), 0);
      chk("to_busy", int'(busy), 0);
      chk("to_pulses", n_a + n_b + n_s, 1);
`else
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         step(1'b0);
         if (state != 2'd1) bad++;
      end
      chk("hold_bad_cycles", bad, 0);
      chk("hold_pulses", n_a + n_b + n_s, 1);
`endif
      // reset while in HAVE_B, with the button still held through release
      do_reset();
      clr();
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(1'b1);
         found = save_A;
      end
      chk("hb_a_found", int'(found), 1);
      repeat (10) step(1'b0);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(1'b1);
         found = save_B;
      end
      chk("hb_b_found", int'(found), 1);
      chk("hb_b_state", int'(state), 2);
      rst = 1'b1;
      #1;
      chk("hb_rst_state", int'(state), 0);
      chk("hb_rst_busy", int'(busy), 0);
      clr();
      repeat (3) step(1'b1);
      rst = 1'b0;
      repeat (20) step(1'b1);
      chk("hb_show", n_s, 0);
      chk("hb_save_B", n_b, 0);
      chk("hb_save_A", n_a, 1);
      chk("hb_state", int'(state), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
